// File: rtl/ads1278_pkg.sv
// rtl/ads1278_pkg.sv - constants, state encoding and channel-mask helpers shared with the ADS1278 driver
package ads1278_pkg;

  localparam int P_CH_NUM   = 8;
  localparam int P_SAMPLE_W = 24;
  localparam int P_FRAME_W  = 192;
  localparam int P_CH_ID_W  = 3;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Lowest enabled channel; descending scan lets the smallest index win.
  function automatic logic [P_CH_ID_W-1:0] first_ch(input logic [P_CH_NUM-1:0] mask);
    first_ch = '0;
    for (int k = P_CH_NUM - 1; k >= 0; k--) begin
      if (mask[k]) first_ch = P_CH_ID_W'(k);
    end
  endfunction

  function automatic logic [P_CH_ID_W-1:0] last_ch(input logic [P_CH_NUM-1:0] mask);
    last_ch = '0;
    for (int k = 0; k < P_CH_NUM; k++) begin
      if (mask[k]) last_ch = P_CH_ID_W'(k);
    end
  endfunction

  // Next enabled channel above cur; returns cur when none is left.
  function automatic logic [P_CH_ID_W-1:0] next_ch(input logic [P_CH_NUM-1:0] mask,
                                                   input logic [P_CH_ID_W-1:0] cur);
    next_ch = cur;
    for (int k = P_CH_NUM - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) next_ch = P_CH_ID_W'(k);
    end
  endfunction

endpackage

// File: rtl/ads1278_ch_acc.sv
// rtl/ads1278_ch_acc.sv - single-channel sign-extending accumulator with clear and shift-out
module ads1278_ch_acc
  import ads1278_pkg::*;
#(
  parameter int P_AVG_LOG2 = 4
) (
  input  logic                  i_sysclk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_add,
  input  logic                  i_last,
  input  logic [P_SAMPLE_W-1:0] i_sample,
  output logic [P_SAMPLE_W-1:0] o_result
);

  localparam int W = P_SAMPLE_W + P_AVG_LOG2;

  logic signed [W-1:0] acc;
  logic signed [W-1:0] sample_ext;
  logic signed [W-1:0] sum;

  // W bits hold 2^P_AVG_LOG2 full-scale samples, so the sum never wraps.
  assign sample_ext = W'($signed(i_sample));
  assign sum        = acc + sample_ext;

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc      <= '0;
      o_result <= '0;
    end else if (i_clear) begin
      acc <= '0;
    end else if (i_add) begin
      if (i_last) begin
        acc      <= '0;
        o_result <= sum[W-1:P_AVG_LOG2];
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/ads1278_frame_avg.sv
// rtl/ads1278_frame_avg.sv - averages 2^P_AVG_LOG2 ADS1278 frames and serializes the enabled channels
module ads1278_frame_avg #(
  parameter int         P_AVG_LOG2 = 4,
  parameter logic [7:0] P_CH_MASK  = 8'b1111_1111
) (
  input  logic         i_sysclk,
  input  logic         i_rst_n,
  input  logic [191:0] i_frame_data,
  input  logic         i_frame_valid,
  output logic         o_frame_ready,
  input  logic         i_clear,
  output logic [23:0]  o_ch_data,
  output logic [2:0]   o_ch_id,
  output logic         o_ch_last,
  output logic         o_ch_valid,
  input  logic         i_ch_ready,
  output logic [15:0]  o_frame_cnt
);

  import ads1278_pkg::*;

  localparam int                   CNT_W    = P_AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((1 << P_AVG_LOG2) - 1);
  localparam logic [P_CH_ID_W-1:0] CH_FIRST = first_ch(P_CH_MASK);
  localparam logic [P_CH_ID_W-1:0] CH_LAST  = last_ch(P_CH_MASK);

  if (P_CH_MASK == 8'd0) begin : g_bad_mask
    $error("ads1278_frame_avg: P_CH_MASK must enable at least one channel");
  end
  if (P_AVG_LOG2 < 0 || P_AVG_LOG2 > 8) begin : g_bad_avg
    $error("ads1278_frame_avg: P_AVG_LOG2 must be within 0..8");
  end

  state_t                  state;
  logic [CNT_W-1:0]        in_cnt;
  logic                    accept;
  logic                    in_last;
  logic [P_SAMPLE_W-1:0]   ch_result [P_CH_NUM];
  logic [P_CH_ID_W-1:0]    ch_next;

  assign accept  = (state == ST_ACC) && o_frame_ready && i_frame_valid;
  assign in_last = (in_cnt == CNT_LAST);
  assign ch_next = next_ch(P_CH_MASK, o_ch_id);

  // Result registers only change on the final accept, so the mux is stable while draining.
  assign o_ch_data = ch_result[o_ch_id];

  for (genvar g = 0; g < P_CH_NUM; g++) begin : g_ch
    ads1278_ch_acc #(
      .P_AVG_LOG2(P_AVG_LOG2)
    ) u_ch_acc (
      .i_sysclk (i_sysclk),
      .i_rst_n  (i_rst_n),
      .i_clear  (i_clear),
      .i_add    (accept),
      .i_last   (in_last),
      .i_sample (i_frame_data[P_SAMPLE_W*g +: P_SAMPLE_W]),
      .o_result (ch_result[g])
    );
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_ACC;
      in_cnt        <= '0;
      o_frame_ready <= 1'b0;
      o_ch_valid    <= 1'b0;
      o_ch_id       <= '0;
      o_ch_last     <= 1'b0;
      o_frame_cnt   <= '0;
    end else if (i_clear) begin
      // Abort wins over any handshake; the drained-frame count is kept.
      state         <= ST_ACC;
      in_cnt        <= '0;
      o_frame_ready <= 1'b1;
      o_ch_valid    <= 1'b0;
      o_ch_id       <= '0;
      o_ch_last     <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          o_frame_ready <= 1'b1;
          if (accept) begin
            if (in_last) begin
              in_cnt        <= '0;
              state         <= ST_OUT;
              o_frame_ready <= 1'b0;
              o_ch_valid    <= 1'b1;
              o_ch_id       <= CH_FIRST;
              o_ch_last     <= (CH_FIRST == CH_LAST);
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (o_ch_valid && i_ch_ready) begin
            if (o_ch_last) begin
              state         <= ST_ACC;
              o_frame_ready <= 1'b1;
              o_ch_valid    <= 1'b0;
              o_ch_last     <= 1'b0;
              o_frame_cnt   <= o_frame_cnt + 16'd1;
            end else begin
              o_ch_id   <= ch_next;
              o_ch_last <= (ch_next == CH_LAST);
            end
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_ads1278_frame_avg.sv
// tb/tb_ads1278_frame_avg.sv - directed self-checking bench for ads1278_frame_avg
module tb_ads1278_frame_avg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [191:0] frame_data;
  logic         fv;
  logic         tgt;
  logic         clr;
  logic         ch_ready;

  logic         valid_a, ready_a, last_a, chv_a;
  logic [23:0]  data_a;
  logic [2:0]   id_a;
  logic [15:0]  cnt_a;

  logic         valid_m, ready_m, last_m, chv_m;
  logic [23:0]  data_m;
  logic [2:0]   id_m;
  logic [15:0]  cnt_m;

  int           checks = 0;
  int           errors = 0;
  logic [23:0]  exp_d [8];

  always #5 clk = ~clk;

  assign valid_a = fv & ~tgt;
  assign valid_m = fv & tgt;

  ads1278_frame_avg #(.P_AVG_LOG2(2), .P_CH_MASK(8'b1111_1111)) u_dut (
    .i_sysclk      (clk),
    .i_rst_n       (rst_n),
    .i_frame_data  (frame_data),
    .i_frame_valid (valid_a),
    .o_frame_ready (ready_a),
    .i_clear       (clr),
    .o_ch_data     (data_a),
    .o_ch_id       (id_a),
    .o_ch_last     (last_a),
    .o_ch_valid    (chv_a),
    .i_ch_ready    (ch_ready),
    .o_frame_cnt   (cnt_a)
  );

  ads1278_frame_avg #(.P_AVG_LOG2(2), .P_CH_MASK(8'b1000_0001)) u_dut_mask (
    .i_sysclk      (clk),
    .i_rst_n       (rst_n),
    .i_frame_data  (frame_data),
    .i_frame_valid (valid_m),
    .o_frame_ready (ready_m),
    .i_clear       (1'b0),
    .o_ch_data     (data_m),
    .o_ch_id       (id_m),
    .o_ch_last     (last_m),
    .o_ch_valid    (chv_m),
    .i_ch_ready    (1'b1),
    .o_frame_cnt   (cnt_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] pack8(input logic [23:0] c0, c1, c2, c3, c4, c5, c6, c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic send4(input logic [191:0] f0, f1, f2, f3);
    logic [191:0] f [4];
    f = '{f0, f1, f2, f3};
    for (int i = 0; i < 4; i++) begin
      frame_data = f[i];
      fv = 1'b1;
      @(negedge clk);
    end
    fv = 1'b0;
  endtask

  task automatic drain(input int bp_id, input logic [15:0] cnt_exp);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("valid_b%0d", k), 32'(chv_a), 32'd1);
      chk($sformatf("id_b%0d", k), 32'(id_a), 32'(k));
      chk($sformatf("data_b%0d", k), 32'(data_a), 32'(exp_d[k]));
      chk($sformatf("last_b%0d", k), 32'(last_a), 32'(k == 7));
      chk($sformatf("fready_b%0d", k), 32'(ready_a), 32'd0);
      if (k == bp_id) begin
        ch_ready = 1'b0;
        fv = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("hold_id_c%0d", c), 32'(id_a), 32'(k));
          chk($sformatf("hold_data_c%0d", c), 32'(data_a), 32'(exp_d[k]));
          chk($sformatf("hold_valid_c%0d", c), 32'(chv_a), 32'd1);
          chk($sformatf("hold_fready_c%0d", c), 32'(ready_a), 32'd0);
        end
        fv = 1'b0;
        ch_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("valid_after_drain", 32'(chv_a), 32'd0);
    chk("frame_cnt_after_drain", 32'(cnt_a), 32'(cnt_exp));
    chk("fready_after_drain", 32'(ready_a), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; frame_data = '0; fv = 1'b0; tgt = 1'b0; clr = 1'b0; ch_ready = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("rst_fready", 32'(ready_a), 32'd0);
    chk("rst_valid", 32'(chv_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_id", 32'(id_a), 32'd0);
    chk("rst_last", 32'(last_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fready_after_release", 32'(ready_a), 32'd1);

    // Mean, floor rounding of negatives, full scale both signs, backpressure at id 3.
    send4(pack8(24'd100, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 24'd1, 24'hFFFFFF, 24'd0, 24'd7),
          pack8(24'd200, 24'hFFFFFE, 24'h7FFFFF, 24'h800000, 24'd2, 24'd0,     24'd0, 24'd7),
          pack8(24'd300, 24'hFFFFFD, 24'h7FFFFF, 24'h800000, 24'd3, 24'd0,     24'd0, 24'd7),
          pack8(24'd400, 24'hFFFFFC, 24'h7FFFFF, 24'h800000, 24'd5, 24'd0,     24'd0, 24'd7));
    exp_d = '{24'd250, 24'hFFFFFD, 24'h7FFFFF, 24'h800000, 24'd2, 24'hFFFFFF, 24'd0, 24'd7};
    drain(3, 16'd1);

    // Masked instance: only channels 0 and 7.
    tgt = 1'b1;
    send4(pack8(24'd100, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd7),
          pack8(24'd200, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd7),
          pack8(24'd300, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd7),
          pack8(24'd400, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd7));
    chk("mask_b0_valid", 32'(chv_m), 32'd1);
    chk("mask_b0_id", 32'(id_m), 32'd0);
    chk("mask_b0_data", 32'(data_m), 32'd250);
    chk("mask_b0_last", 32'(last_m), 32'd0);
    @(negedge clk);
    chk("mask_b1_valid", 32'(chv_m), 32'd1);
    chk("mask_b1_id", 32'(id_m), 32'd7);
    chk("mask_b1_data", 32'(data_m), 32'd7);
    chk("mask_b1_last", 32'(last_m), 32'd1);
    @(negedge clk);
    chk("mask_done_valid", 32'(chv_m), 32'd0);
    chk("mask_cnt", 32'(cnt_m), 32'd1);
    chk("mask_fready", 32'(ready_m), 32'd1);
    tgt = 1'b0;

    // Clear after 2 of 4 frames discards the partial sum.
    frame_data = pack8(24'd1000, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    fv = 1'b1;
    repeat (2) @(negedge clk);
    fv = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt_kept", 32'(cnt_a), 32'd1);
    chk("clr_valid", 32'(chv_a), 32'd0);
    chk("clr_fready", 32'(ready_a), 32'd1);
    frame_data = pack8(24'd8, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    send4(frame_data, frame_data, frame_data, frame_data);
    exp_d = '{24'd8, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
    drain(-1, 16'd2);

    // Clear during output at id 2: frame dropped and not counted.
    send4(frame_data, frame_data, frame_data, frame_data);
    chk("oclr_b0_id", 32'(id_a), 32'd0);
    @(negedge clk);
    chk("oclr_b1_id", 32'(id_a), 32'd1);
    @(negedge clk);
    chk("oclr_b2_id", 32'(id_a), 32'd2);
    ch_ready = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("oclr_valid_drop", 32'(chv_a), 32'd0);
    chk("oclr_cnt", 32'(cnt_a), 32'd2);
    chk("oclr_fready", 32'(ready_a), 32'd1);
    @(negedge clk);
    chk("oclr_valid_stays", 32'(chv_a), 32'd0);
    ch_ready = 1'b1;

    // Reset during output at id 2.
    send4(frame_data, frame_data, frame_data, frame_data);
    @(negedge clk);
    @(negedge clk);
    chk("orst_b2_id", 32'(id_a), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("orst_valid", 32'(chv_a), 32'd0);
    chk("orst_cnt", 32'(cnt_a), 32'd0);
    chk("orst_fready", 32'(ready_a), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("orst_no_partial_c%0d", c), 32'(chv_a), 32'd0);
    end
    chk("orst_fready_back", 32'(ready_a), 32'd1);
    frame_data = pack8(24'd4, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
    send4(frame_data, frame_data, frame_data, frame_data);
    exp_d = '{24'd4, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
    drain(-1, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
